// File: rtl/nonce_sweep_ctrl_pkg.sv
// Shared types and constants for the nonce sweep controller.
// Widths, FSM state encoding, register codes and the nonce insert helper.
package goldminer_pkg;

  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  // Control register bit positions used by the Avalon-MM front end.
  localparam int CTRL_ABORT_BIT = 0;
  localparam int CTRL_ACK_BIT   = 1;

  localparam logic [7:0] CODE_ABORT = 8'h01;
  localparam logic [7:0] CODE_ACK   = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Overwrite one 32-bit word of the block with the nonce.
  function automatic logic [BLOCK_W-1:0] insert_nonce(
    input logic [BLOCK_W-1:0] blk,
    input logic [NONCE_W-1:0] nonce,
    input int                 word
  );
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[word*NONCE_W +: NONCE_W] = nonce;
    return r;
  endfunction

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Bundle of job, core and result signals around the sweep controller.
// slave is the controller's view, master is the surrounding system's view.
interface nonce_sweep_ctrl_if #(
  parameter int CNT_W = 32
);
  import goldminer_pkg::*;

  logic                 job_valid;
  logic                 job_ready;
  logic [BLOCK_W-1:0]   job_block;
  logic [HASH_W-1:0]    job_target;
  logic [NONCE_W-1:0]   job_nonce_start;
  logic [NONCE_W-1:0]   job_nonce_end;
  logic                 abort;
  logic                 sha_start;
  logic [BLOCK_W-1:0]   sha_data;
  logic                 sha_done;
  logic [HASH_W-1:0]    sha_hash;
  logic                 found_valid;
  logic [NONCE_W-1:0]   found_nonce;
  logic [HASH_W-1:0]    found_hash;
  logic                 found_ack;
  logic                 busy;
  logic                 exhausted;
  logic [CNT_W-1:0]     hashes_done;

  modport slave (
    input  job_valid, job_block, job_target,
    input  job_nonce_start, job_nonce_end, abort,
    input  sha_done, sha_hash, found_ack,
    output job_ready, sha_start, sha_data,
    output found_valid, found_nonce, found_hash,
    output busy, exhausted, hashes_done
  );

  modport master (
    output job_valid, job_block, job_target,
    output job_nonce_start, job_nonce_end, abort,
    output sha_done, sha_hash, found_ack,
    input  job_ready, sha_start, sha_data,
    input  found_valid, found_nonce, found_hash,
    input  busy, exhausted, hashes_done
  );

endinterface

// File: rtl/nonce_sweep_ctrl_hash_lt.sv
// Unsigned magnitude compare of a hash against a target.
// Purely combinational; the MSB of each operand is the most significant.
module hash_lt_target #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  // Strict less-than: equality is not a win.
  always_comb begin
    lt = (a < b);
  end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Mining job scheduler: walks one SHA-256 core through a nonce range.
// Inserts each nonce into the block, checks hashes, reports winners.
module nonce_sweep_ctrl
  import goldminer_pkg::*;
#(
  parameter int NONCE_WORD = 3,
  parameter int CNT_W      = 32
) (
  input logic clk,
  input logic reset,
  nonce_sweep_ctrl_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic [BLOCK_W-1:0] block_q;
  logic [BLOCK_W-1:0] data_q;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_q;
  logic [HASH_W-1:0]  fhash_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] end_q;
  logic [NONCE_W-1:0] fnonce_q;
  logic [NONCE_W-1:0] nonce_nx;
  logic [CNT_W-1:0]   count_q;

  logic win;
  logic last;
  logic accept;
  logic advance;
  logic report;
  logic take_hash;

  hash_lt_target #(.W(HASH_W)) u_lt (
    .a  (hash_q),
    .b  (target_q),
    .lt (win)
  );

  assign last      = (nonce_q == end_q);
  assign nonce_nx  = nonce_q + NONCE_W'(1);
  assign accept    = (state_q == S_IDLE) && bus.job_valid;
  assign advance   = (state_q != S_IDLE) && (state_d == S_ISSUE);
  assign report    = (state_q == S_CHECK) && (state_d == S_REPORT);
  assign take_hash = (state_q == S_WAIT) && bus.sha_done && !bus.abort;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort outranks sha_done and found_ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.job_valid) state_d = S_ISSUE;
      S_ISSUE:  state_d = bus.abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.abort)         state_d = bus.sha_done ? S_IDLE : S_DRAIN;
        else if (bus.sha_done) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.abort) state_d = S_IDLE;
        else if (win)  state_d = S_REPORT;
        else if (last) state_d = S_DONE;
        else           state_d = S_ISSUE;
      end
      S_REPORT: begin
        if (bus.abort)          state_d = S_IDLE;
        else if (bus.found_ack) state_d = last ? S_DONE : S_ISSUE;
      end
      S_DRAIN:  if (bus.abort || bus.sha_done) state_d = S_IDLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status and strobe outputs decoded from the current state.
  always_comb begin
    bus.job_ready   = (state_q == S_IDLE);
    bus.busy        = (state_q != S_IDLE);
    bus.sha_start   = (state_q == S_ISSUE);
    bus.found_valid = (state_q == S_REPORT);
    bus.exhausted   = (state_q == S_DONE);
    bus.sha_data    = data_q;
    bus.found_nonce = fnonce_q;
    bus.found_hash  = fhash_q;
    bus.hashes_done = count_q;
  end

  // Job latch, nonce stepping, hash capture and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_q  <= '0;
      data_q   <= '0;
      target_q <= '0;
      hash_q   <= '0;
      fhash_q  <= '0;
      nonce_q  <= '0;
      end_q    <= '0;
      fnonce_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        block_q  <= bus.job_block;
        target_q <= bus.job_target;
        end_q    <= bus.job_nonce_end;
        nonce_q  <= bus.job_nonce_start;
        data_q   <= insert_nonce(bus.job_block,
                                 bus.job_nonce_start,
                                 NONCE_WORD);
        count_q  <= '0;
      end
      if (advance) begin
        nonce_q <= nonce_nx;
        data_q  <= insert_nonce(block_q, nonce_nx, NONCE_WORD);
      end
      if (take_hash) begin
        hash_q <= bus.sha_hash;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end
      if (report) begin
        fnonce_q <= nonce_q;
        fhash_q  <= hash_q;
      end
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Scenario bench for nonce_sweep_ctrl with a latency-programmable core model.
// Expected found results and issued blocks are queued and compared on output.
module tb_nonce_sweep_ctrl;

  localparam int NW = 3;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  nonce_sweep_ctrl_if #(.CNT_W(32)) bus ();

  nonce_sweep_ctrl #(.NONCE_WORD(NW), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model state.
  int            lat;
  int            hmode;
  int            ccnt;
  logic          cbusy;
  logic [31:0]   cnonce;
  logic [255:0]  t4;
  logic [511:0]  start_q[$];

  // Scoreboard queues.
  logic [31:0]   exp_nonce_q[$];
  logic [255:0]  exp_hash_q[$];
  logic [31:0]   obs_nonce_q[$];
  logic [255:0]  obs_hash_q[$];
  logic [511:0]  exp_data_q[$];

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    logic [255:0] h;
    if (hmode == 1) begin
      if (n == 32'd9)       h = t4;
      else if (n == 32'd10) h = t4 - 256'd1;
      else                  h = '1;
    end else begin
      h = {8{n ^ 32'h5A5A_0F0F}};
    end
    return h;
  endfunction

  function automatic logic [511:0] put_nonce(input logic [511:0] b,
                                             input logic [31:0] n);
    logic [511:0] r;
    r = b;
    r[127:96] = n;
    return r;
  endfunction

  // SHA core stand-in: one result lat cycles after each start.
  always @(negedge clk) begin
    bus.sha_done = 1'b0;
    if (reset) begin
      cbusy = 1'b0;
      ccnt  = 0;
    end else begin
      if (cbusy) begin
        if (ccnt <= 1) begin
          bus.sha_done = 1'b1;
          bus.sha_hash = hash_of(cnonce);
          cbusy = 1'b0;
        end else begin
          ccnt = ccnt - 1;
        end
      end
      if (bus.sha_start) begin
        cbusy  = 1'b1;
        ccnt   = lat;
        cnonce = bus.sha_data[NW*32 +: 32];
        start_q.push_back(bus.sha_data);
      end
    end
  end

  task automatic send_job(input logic [511:0] blk, input logic [255:0] tgt,
                          input logic [31:0] s, input logic [31:0] e);
    start_q.delete();
    obs_nonce_q.delete();
    obs_hash_q.delete();
    @(negedge clk);
    bus.job_block       = blk;
    bus.job_target      = tgt;
    bus.job_nonce_start = s;
    bus.job_nonce_end   = e;
    bus.job_valid       = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  // Acks every report, collects results, stops the cycle after exhausted.
  task automatic sweep(input int budget, output int nexh,
                       output logic rdy_after, output logic tmo);
    nexh = 0;
    rdy_after = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.found_valid && !bus.found_ack) begin
        obs_nonce_q.push_back(bus.found_nonce);
        obs_hash_q.push_back(bus.found_hash);
        bus.found_ack = 1'b1;
      end else begin
        bus.found_ack = 1'b0;
      end
      if (bus.exhausted) begin
        nexh++;
        @(negedge clk);
        rdy_after = bus.job_ready;
        if (bus.exhausted) nexh++;
        tmo = 1'b0;
        break;
      end
    end
    bus.found_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (bus.job_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_job_ready got %b want 1", bus.job_ready);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    if (bus.sha_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sha_start got %b want 0", bus.sha_start);
    end
    if (bus.found_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_found_valid got %b want 0", bus.found_valid);
    end
    if (bus.exhausted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exhausted got %b want 0", bus.exhausted);
    end
    if (bus.hashes_done !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_hashes_done got %0d want 0", bus.hashes_done);
    end
    if (bus.sha_data !== 512'd0 || bus.found_nonce !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h want 0", bus.sha_data[127:96],
               bus.found_nonce);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Shared result checks for each scenario are written inline per task.
  task automatic test_all_win();
    logic [511:0] blk;
    int nexh;
    logic rdy, tmo;
    lat = 64;
    hmode = 0;
    blk = {16{32'hC0DE_0000}};
    for (int n = 5; n <= 7; n++) begin
      exp_nonce_q.push_back(32'(n));
      exp_hash_q.push_back(hash_of(32'(n)));
      exp_data_q.push_back(put_nonce(blk, 32'(n)));
    end
    send_job(blk, '1, 32'd5, 32'd7);
    sweep(2000, nexh, rdy, tmo);
    vectors++;
    if (tmo || nexh != 1) begin
      miscompares++;
      $display("FAIL win_exhausted got %0d pulses tmo=%b want 1", nexh, tmo);
    end
    vectors++;
    if (obs_nonce_q.size() != 3) begin
      miscompares++;
      $display("FAIL win_count got %0d want 3", obs_nonce_q.size());
    end
    while (exp_nonce_q.size() > 0 && obs_nonce_q.size() > 0) begin
      logic [31:0]  en, on;
      logic [255:0] eh, oh;
      en = exp_nonce_q.pop_front();
      eh = exp_hash_q.pop_front();
      on = obs_nonce_q.pop_front();
      oh = obs_hash_q.pop_front();
      vectors++;
      if (on !== en || oh !== eh) begin
        miscompares++;
        $display("FAIL win_found got %h want %h", on, en);
      end
    end
    while (exp_data_q.size() > 0 && start_q.size() > 0) begin
      logic [511:0] ed, od;
      ed = exp_data_q.pop_front();
      od = start_q.pop_front();
      vectors++;
      if (od !== ed) begin
        miscompares++;
        $display("FAIL win_sha_data got %h want %h", od[127:96], ed[127:96]);
      end
    end
    vectors++;
    if (bus.hashes_done !== 32'd3) begin
      miscompares++;
      $display("FAIL win_hashes_done got %0d want 3", bus.hashes_done);
    end
    exp_nonce_q.delete();
    exp_hash_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_single();
    int nexh;
    logic rdy, tmo;
    lat = 5;
    hmode = 0;
    send_job({16{32'h1111_2222}}, '0, 32'h10, 32'h10);
    sweep(200, nexh, rdy, tmo);
    vectors += 4;
    if (start_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_starts got %0d want 1", start_q.size());
    end
    if (obs_nonce_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_found got %0d want 0", obs_nonce_q.size());
    end
    if (tmo || nexh != 1) begin
      miscompares++;
      $display("FAIL single_exhausted got %0d tmo=%b want 1", nexh, tmo);
    end
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready_after got %b want 1", rdy);
    end
  endtask

  task automatic test_wrap();
    logic [511:0] blk;
    logic [31:0]  seq[4];
    int nexh;
    logic rdy, tmo;
    lat = 4;
    hmode = 0;
    blk = {16{32'hABCD_EF01}};
    seq[0] = 32'hFFFF_FFFE;
    seq[1] = 32'hFFFF_FFFF;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0001;
    for (int i = 0; i < 4; i++) exp_data_q.push_back(put_nonce(blk, seq[i]));
    send_job(blk, '0, 32'hFFFF_FFFE, 32'h0000_0001);
    sweep(400, nexh, rdy, tmo);
    vectors += 2;
    if (start_q.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_starts got %0d want 4", start_q.size());
    end
    if (tmo || nexh != 1) begin
      miscompares++;
      $display("FAIL wrap_exhausted got %0d tmo=%b want 1", nexh, tmo);
    end
    while (exp_data_q.size() > 0 && start_q.size() > 0) begin
      logic [511:0] ed, od;
      ed = exp_data_q.pop_front();
      od = start_q.pop_front();
      vectors++;
      if (od !== ed) begin
        miscompares++;
        $display("FAIL wrap_nonce got %h want %h", od[127:96], ed[127:96]);
      end
    end
    exp_data_q.delete();
  endtask

  task automatic test_equal();
    int nexh;
    logic rdy, tmo;
    lat = 6;
    hmode = 1;
    t4 = {32'h0000_1000, 224'd0};
    exp_nonce_q.push_back(32'd10);
    exp_hash_q.push_back(t4 - 256'd1);
    send_job({16{32'h7777_0000}}, t4, 32'd9, 32'd10);
    sweep(300, nexh, rdy, tmo);
    vectors += 3;
    if (obs_nonce_q.size() != 1) begin
      miscompares++;
      $display("FAIL equal_count got %0d want 1", obs_nonce_q.size());
    end else begin
      logic [31:0]  en;
      logic [255:0] eh;
      en = exp_nonce_q.pop_front();
      eh = exp_hash_q.pop_front();
      if (obs_nonce_q[0] !== en) begin
        miscompares++;
        $display("FAIL equal_nonce got %h want %h", obs_nonce_q[0], en);
      end
      if (obs_hash_q[0] !== eh) begin
        miscompares++;
        $display("FAIL equal_hash got %h want %h", obs_hash_q[0], eh);
      end
    end
    vectors++;
    if (bus.hashes_done !== 32'd2 || tmo) begin
      miscompares++;
      $display("FAIL equal_hashes_done got %0d want 2", bus.hashes_done);
    end
    exp_nonce_q.delete();
    exp_hash_q.delete();
    hmode = 0;
  endtask

  task automatic test_abort();
    logic [511:0] blk2;
    int   nexh, w;
    logic rdy, tmo, early, seen;
    lat = 20;
    hmode = 0;
    send_job({16{32'h3333_4444}}, '0, 32'd0, 32'd100);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.sha_start) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    vectors += 2;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_drain_busy got %b want 1", bus.busy);
    end
    if (bus.hashes_done !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_hashes got %0d want 0", bus.hashes_done);
    end
    early = 1'b0;
    w = 0;
    while (!bus.job_ready && w < 100) begin
      @(negedge clk);
      w++;
      if (bus.job_ready && cbusy) early = 1'b1;
    end
    vectors += 3;
    if (!bus.job_ready || early) begin
      miscompares++;
      $display("FAIL abort_idle got rdy=%b early=%b want 1/0",
               bus.job_ready, early);
    end
    if (start_q.size() != 1) begin
      miscompares++;
      $display("FAIL abort_starts got %0d want 1", start_q.size());
    end
    if (cbusy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_core_pending got %b want 0", cbusy);
    end
    blk2 = {16{32'h9999_8888}};
    exp_data_q.push_back(put_nonce(blk2, 32'h55));
    send_job(blk2, '0, 32'h55, 32'h55);
    sweep(200, nexh, rdy, tmo);
    vectors += 2;
    if (start_q.size() < 1) begin
      miscompares++;
      $display("FAIL abort_new_start got 0 want 1");
    end else begin
      logic [511:0] ed;
      ed = exp_data_q.pop_front();
      if (start_q[0] !== ed) begin
        miscompares++;
        $display("FAIL abort_new_data got %h want %h",
                 start_q[0][127:96], ed[127:96]);
      end
    end
    if (tmo || nexh != 1 || bus.hashes_done !== 32'd1) begin
      miscompares++;
      $display("FAIL abort_new_job got exh=%0d hashes=%0d want 1/1",
               nexh, bus.hashes_done);
    end
    exp_data_q.delete();
  endtask

  task automatic test_reset_report();
    logic seen;
    lat = 5;
    hmode = 0;
    send_job({16{32'h5555_6666}}, '1, 32'd1, 32'd3);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.found_valid) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rr_report got 0 want 1");
    end
    reset = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (bus.found_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_found_valid got %b want 0", bus.found_valid);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_busy got %b want 0", bus.busy);
    end
    if (bus.job_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rr_job_ready got %b want 1", bus.job_ready);
    end
    if (bus.hashes_done !== 32'd0) begin
      miscompares++;
      $display("FAIL rr_hashes_done got %0d want 0", bus.hashes_done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lat = 5;
    hmode = 0;
    t4 = '0;
    cbusy = 1'b0;
    ccnt = 0;
    cnonce = '0;
    reset = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_block = '0;
    bus.job_target = '0;
    bus.job_nonce_start = '0;
    bus.job_nonce_end = '0;
    bus.abort = 1'b0;
    bus.sha_done = 1'b0;
    bus.sha_hash = '0;
    bus.found_ack = 1'b0;
    test_reset();
    test_all_win();
    test_single();
    test_wrap();
    test_equal();
    test_abort();
    test_reset_report();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
